// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
//   Shared definitions for the CSR bus front end:
//   - Zicsr funct3 codes
//   - bus modify codes (none / write / set / clear)
//   - read-only CSR address prefix
//   - FSM state encoding of csr_access_unit
//   - csr_decode(): funct3 + src_zero + address prefix -> bus modify + illegal
// ---------------------------------------------------------------------------
package csr_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [2:0] {
    CSR_MOD_NONE  = 3'b000,
    CSR_MOD_WRITE = 3'b001,
    CSR_MOD_SET   = 3'b010,
    CSR_MOD_CLEAR = 3'b011
  } csr_mod_e;

  // CSR addresses with [11:10] == 2'b11 are read-only.
  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_RESP   = 2'd3
  } csr_state_e;

  typedef struct packed {
    csr_mod_e modify;
    logic     illegal;
  } csr_decode_t;

  // Set/clear with a zero source are pure reads and never touch the CSR.
  // An illegal request is still read on the bus, but never modifies it.
  function automatic csr_decode_t csr_decode(input logic [2:0] funct3,
                                             input logic       src_zero,
                                             input logic [1:0] addr_prefix);
    csr_decode_t d;
    d.modify  = CSR_MOD_NONE;
    d.illegal = 1'b0;
    case (funct3)
      F3_CSRRW, F3_CSRRWI: d.modify = CSR_MOD_WRITE;
      F3_CSRRS, F3_CSRRSI: d.modify = src_zero ? CSR_MOD_NONE : CSR_MOD_SET;
      F3_CSRRC, F3_CSRRCI: d.modify = src_zero ? CSR_MOD_NONE : CSR_MOD_CLEAR;
      default:             d.illegal = 1'b1;
    endcase
    if ((d.modify != CSR_MOD_NONE) && (addr_prefix == CSR_RO_PREFIX)) begin
      d.illegal = 1'b1;
    end
    if (d.illegal) begin
      d.modify = CSR_MOD_NONE;
    end
    return d;
  endfunction

endpackage

// File: rtl/csr_rdata_mux.sv
// ---------------------------------------------------------------------------
// csr_rdata_mux
//   Combines the registered read data of all CSR peripherals.
//   Ports:
//     slv_rdata   in  32*NUM_SLAVES  peripheral rdata, slave i at [32*i+:32]
//     slv_valid   in  NUM_SLAVES     peripheral valid
//     rdata       out 32             OR of rdata of all valid slaves
//     any_valid   out 1              at least one slave responded
//     multi_valid out 1              more than one slave responded
// ---------------------------------------------------------------------------
module csr_rdata_mux #(
  parameter int NUM_SLAVES = 8
) (
  input  logic [32*NUM_SLAVES-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]    slv_valid,
  output logic [31:0]              rdata,
  output logic                     any_valid,
  output logic                     multi_valid
);

  logic seen;

  always_comb begin
    rdata       = '0;
    multi_valid = 1'b0;
    seen        = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slv_valid[i]) begin
        rdata = rdata | slv_rdata[32*i +: 32];
        if (seen) begin
          multi_valid = 1'b1;
        end
        seen = 1'b1;
      end
    end
  end

  assign any_valid = |slv_valid;

endmodule

// File: rtl/csr_access_unit.sv
// ---------------------------------------------------------------------------
// csr_access_unit
//   Front end of the CSR bus. Takes one decoded Zicsr instruction per
//   handshake, drives the shared peripheral bus for one cycle, samples the
//   registered peripheral response and hands read data plus an illegal-CSR
//   flag back to the pipeline.
//
//   Handshakes: a transfer happens on a rising edge where valid && ready.
//   req_ready is high only in IDLE; rsp_valid is high only in RESP and the
//   response fields are held until rsp_ready is seen.
//
//   Ports:
//     clk, rstn                     clock, synchronous active-low reset
//     req_valid/req_ready           request handshake
//     req_funct3, req_src,
//     req_src_zero, req_addr        decoded Zicsr request
//     csr_read, csr_modify,
//     csr_wdata, csr_addr           shared bus to all peripherals (registered)
//     slv_rdata, slv_valid          registered peripheral responses
//     rsp_valid/rsp_ready           response handshake
//     rsp_rdata, rsp_illegal        old CSR value (0 if illegal), illegal flag
// ---------------------------------------------------------------------------
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int NUM_SLAVES = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_src,
  input  logic                     req_src_zero,
  input  logic [11:0]              req_addr,
  output logic                     csr_read,
  output logic [2:0]               csr_modify,
  output logic [31:0]              csr_wdata,
  output logic [11:0]              csr_addr,
  input  logic [32*NUM_SLAVES-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]    slv_valid,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_illegal
);

  csr_state_e  state_q, state_d;
  logic        csr_read_q, csr_read_d;
  logic [2:0]  csr_modify_q, csr_modify_d;
  logic [31:0] csr_wdata_q, csr_wdata_d;
  logic [11:0] csr_addr_q, csr_addr_d;
  logic        dec_illegal_q, dec_illegal_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_illegal_q, rsp_illegal_d;

  csr_decode_t dec;
  logic [31:0] mux_rdata;
  logic        any_valid;
  logic        multi_valid;

  assign dec = csr_decode(req_funct3, req_src_zero, req_addr[11:10]);

  csr_rdata_mux #(
    .NUM_SLAVES (NUM_SLAVES)
  ) u_rdata_mux (
    .slv_rdata   (slv_rdata),
    .slv_valid   (slv_valid),
    .rdata       (mux_rdata),
    .any_valid   (any_valid),
    .multi_valid (multi_valid)
  );

  always_comb begin
    state_d       = state_q;
    csr_read_d    = csr_read_q;
    csr_modify_d  = csr_modify_q;
    csr_wdata_d   = csr_wdata_q;
    csr_addr_d    = csr_addr_q;
    dec_illegal_d = dec_illegal_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_illegal_d = rsp_illegal_q;

    case (state_q)
      ST_IDLE: begin
        // The request is decoded here so the bus is live in the very next
        // cycle (ACCESS) straight from flops.
        if (req_valid) begin
          state_d       = ST_ACCESS;
          csr_read_d    = 1'b1;
          csr_modify_d  = dec.modify;
          csr_wdata_d   = req_src;
          csr_addr_d    = req_addr;
          dec_illegal_d = dec.illegal;
        end
      end
      ST_ACCESS: begin
        // Drop the strobes after one cycle so set/clear cannot repeat;
        // the address stays put for the sampling cycle.
        state_d      = ST_SAMPLE;
        csr_read_d   = 1'b0;
        csr_modify_d = CSR_MOD_NONE;
      end
      ST_SAMPLE: begin
        state_d       = ST_RESP;
        rsp_illegal_d = dec_illegal_q | ~any_valid;
        rsp_rdata_d   = (dec_illegal_q | ~any_valid) ? 32'h0 : mux_rdata;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      csr_read_q    <= 1'b0;
      csr_modify_q  <= CSR_MOD_NONE;
      csr_wdata_q   <= '0;
      csr_addr_q    <= '0;
      dec_illegal_q <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      csr_read_q    <= csr_read_d;
      csr_modify_q  <= csr_modify_d;
      csr_wdata_q   <= csr_wdata_d;
      csr_addr_q    <= csr_addr_d;
      dec_illegal_q <= dec_illegal_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign csr_read    = csr_read_q;
  assign csr_modify  = csr_modify_q;
  assign csr_wdata   = csr_wdata_q;
  assign csr_addr    = csr_addr_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_illegal = rsp_illegal_q;

`ifndef SYNTHESIS
  // Overlapping address decode between peripherals is a system bug; the
  // data is still OR-ed so the pipeline keeps running.
  always @(posedge clk) begin
    if (rstn && (state_q == ST_SAMPLE)) begin
      assert (!multi_valid)
        else $error("csr_access_unit: several slaves answered address 0x%03h", csr_addr_q);
    end
  end
`endif

endmodule
